// File: rtl/action_dispatcher.sv
// action_dispatcher: takes one matched packet, resolves its action id through a
// software-written action table, drives the executor start/done protocol under a
// watchdog, and hands a per-packet completion status downstream.
module action_dispatcher #(
   parameter int ACTION_ID_W = 4,
   parameter int TAG_W       = 8,
   parameter int TIMEOUT     = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   // action table programming
   input  logic                   cfg_we_i,
   input  logic [ACTION_ID_W-1:0] cfg_idx_i,
   input  logic [31:0]            cfg_addr_i,
   input  logic                   cfg_en_i,
   // match stage
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [ACTION_ID_W-1:0] in_action_i,
   input  logic [TAG_W-1:0]       in_tag_i,
   // executor
   output logic                   exec_start_o,
   output logic [31:0]            exec_start_addr_o,
   input  logic                   exec_done_i,
   // completion
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [TAG_W-1:0]       out_tag_o,
   output logic [1:0]             out_status_o,
   // status
   output logic                   busy_o,
   output logic [31:0]            cnt_ok_o,
   output logic [15:0]            cnt_err_o
);

   localparam int DEPTH = 1 << ACTION_ID_W;
   localparam int TMR_W = $clog2(TIMEOUT) + 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   localparam logic [1:0] ST_OK   = 2'b00;
   localparam logic [1:0] ST_MISS = 2'b01;
   localparam logic [1:0] ST_TMO  = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WAIT, S_REPORT} state_t;

   typedef struct packed {
      logic [ACTION_ID_W-1:0] action;
      logic [TAG_W-1:0]       tag;
   } req_t;

   state_t                  state, state_nxt;
   req_t                    req;
   logic [DEPTH-1:0][31:0]  tbl_addr;
   logic [DEPTH-1:0]        tbl_en;
   logic [TMR_W-1:0]        timer;
   logic                    accept;
   logic                    ent_en;
   logic [31:0]             ent_addr;
   logic                    tmo_hit;

   // Never accept while the executor still shows done from the previous packet,
   // otherwise a fresh start could be mistaken for an already-finished one.
   assign in_ready_o = (state == S_IDLE) && !exec_done_i;
   assign accept     = in_valid_i && in_ready_o;
   assign busy_o     = (state != S_IDLE);

   // Asynchronous table read; a same-cycle write only lands at the edge, so the
   // lookup naturally sees the old entry.
   assign ent_en   = tbl_en[req.action];
   assign ent_addr = tbl_addr[req.action];
   assign tmo_hit  = (timer == TMR_LAST);

   // Action table: software writes accepted in any state.
   always_ff @(posedge clk) begin
      if (rst) begin
         tbl_addr <= '0;
         tbl_en   <= '0;
      end else if (cfg_we_i) begin
         tbl_addr[cfg_idx_i] <= cfg_addr_i;
         tbl_en[cfg_idx_i]   <= cfg_en_i;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (accept) state_nxt = S_LOOKUP;
         S_LOOKUP: state_nxt = ent_en ? S_WAIT : S_REPORT;
         S_WAIT:   if (exec_done_i || tmo_hit) state_nxt = S_REPORT;
         S_REPORT: if (out_ready_i) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Datapath: request latch, executor drive, watchdog, completion and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         req               <= '0;
         exec_start_o      <= 1'b0;
         exec_start_addr_o <= '0;
         timer             <= '0;
         out_valid_o       <= 1'b0;
         out_tag_o         <= '0;
         out_status_o      <= ST_OK;
         cnt_ok_o          <= '0;
         cnt_err_o         <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) req <= {in_action_i, in_tag_i};
            end
            S_LOOKUP: begin
               if (ent_en) begin
                  exec_start_o      <= 1'b1;
                  exec_start_addr_o <= ent_addr;
                  timer             <= '0;
               end else begin
                  // Invalid entry: report MISS without ever touching the executor.
                  out_valid_o  <= 1'b1;
                  out_tag_o    <= req.tag;
                  out_status_o <= ST_MISS;
               end
            end
            S_WAIT: begin
               timer <= timer + 1'b1;
               // Done takes priority over a coincident watchdog expiry.
               if (exec_done_i) begin
                  exec_start_o <= 1'b0;
                  out_valid_o  <= 1'b1;
                  out_tag_o    <= req.tag;
                  out_status_o <= ST_OK;
               end else if (tmo_hit) begin
                  exec_start_o <= 1'b0;
                  out_valid_o  <= 1'b1;
                  out_tag_o    <= req.tag;
                  out_status_o <= ST_TMO;
               end
            end
            S_REPORT: begin
               if (out_ready_i) begin
                  out_valid_o <= 1'b0;
                  if (out_status_o == ST_OK) begin
                     if (cnt_ok_o != '1) cnt_ok_o <= cnt_ok_o + 1'b1;
                  end else begin
                     if (cnt_err_o != '1) cnt_err_o <= cnt_err_o + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_action_dispatcher.sv
// tb_action_dispatcher: table of directed packet vectors plus hand sequences for
// backpressure, lingering done, same-cycle table write and mid-WAIT reset.
module tb_action_dispatcher;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we_i;
   logic [3:0]  cfg_idx_i;
   logic [31:0] cfg_addr_i;
   logic        cfg_en_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [3:0]  in_action_i;
   logic [7:0]  in_tag_i;
   logic        exec_start_o;
   logic [31:0] exec_start_addr_o;
   logic        exec_done_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [7:0]  out_tag_o;
   logic [1:0]  out_status_o;
   logic        busy_o;
   logic [31:0] cnt_ok_o;
   logic [15:0] cnt_err_o;

   int n_vec = 0;
   int n_err = 0;

   action_dispatcher #(.ACTION_ID_W(4), .TAG_W(8), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_addr_i(cfg_addr_i), .cfg_en_i(cfg_en_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_action_i(in_action_i), .in_tag_i(in_tag_i),
      .exec_start_o(exec_start_o), .exec_start_addr_o(exec_start_addr_o), .exec_done_i(exec_done_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_tag_o(out_tag_o),
      .out_status_o(out_status_o), .busy_o(busy_o), .cnt_ok_o(cnt_ok_o), .cnt_err_o(cnt_err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [3:0]  widx;
      logic [31:0] waddr;
      logic        wen;
      logic [3:0]  act;
      logic [7:0]  tag;
      int          dly;    // cycles after start before done; -1 = never
      int          hold;   // cycles out_ready_i held low
      logic [1:0]  st;
      logic [31:0] eaddr;
      logic [31:0] ok;
      logic [31:0] err;
   } vec_t;

   vec_t vt[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // All tasks start just after a negedge and return just after a negedge.
   task automatic cfg_write(input logic [3:0] idx, input logic [31:0] addr, input logic en);
      cfg_we_i = 1'b1; cfg_idx_i = idx; cfg_addr_i = addr; cfg_en_i = en;
      @(negedge clk);
      cfg_we_i = 1'b0;
   endtask

   // Returns at the negedge after the accept edge (dispatcher in LOOKUP).
   task automatic accept(input logic [3:0] act, input logic [7:0] tag);
      int n = 0;
      while (!in_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", in_ready_o, 1'b1);
      in_valid_i = 1'b1; in_action_i = act; in_tag_i = tag;
      @(negedge clk);
      in_valid_i = 1'b0;
      chk("lookup_busy", busy_o, 1'b1);
      chk("lookup_nostart", exec_start_o, 1'b0);
   endtask

   task automatic run_pkt(input logic [3:0] act, input logic [7:0] tag, input int dly,
                          input int hold, input logic [1:0] st, input logic [31:0] eaddr,
                          input logic [31:0] eok, input logic [31:0] eerr);
      int n;
      accept(act, tag);
      @(negedge clk);
      if (st == 2'b01) begin
         chk("miss_nostart", exec_start_o, 1'b0);
         chk("miss_valid", out_valid_o, 1'b1);
      end else begin
         chk("start_hi", exec_start_o, 1'b1);
         chk("start_addr", exec_start_addr_o, eaddr);
         n = (dly < 0) ? TMO - 1 : dly;
         for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("wait_start", exec_start_o, 1'b1);
            chk("wait_addr", exec_start_addr_o, eaddr);
            chk("wait_noval", out_valid_o, 1'b0);
         end
         if (dly >= 0) exec_done_i = 1'b1;
         @(negedge clk);
         chk("start_drop", exec_start_o, 1'b0);
         chk("done_valid", out_valid_o, 1'b1);
         exec_done_i = 1'b0;
      end
      chk("status", out_status_o, st);
      chk("tag", out_tag_o, tag);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", out_valid_o, 1'b1);
         chk("hold_tag", out_tag_o, tag);
         chk("hold_status", out_status_o, st);
         chk("hold_noready", in_ready_o, 1'b0);
      end
      out_ready_i = 1'b1;
      @(negedge clk);
      out_ready_i = 1'b0;
      chk("hs_valid_lo", out_valid_o, 1'b0);
      chk("hs_idle", busy_o, 1'b0);
      chk("cnt_ok", cnt_ok_o, eok);
      chk("cnt_err", {16'h0, cnt_err_o}, eerr);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      vt[0] = '{1'b1, 4'd3,  32'h40,       1'b1, 4'd3,  8'h5A, 10, 0, 2'b00, 32'h40,       32'd1, 32'd0};
      vt[1] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd7,  8'h11,  0, 0, 2'b01, 32'h0,        32'd1, 32'd1};
      vt[2] = '{1'b1, 4'd5,  32'h1234,     1'b1, 4'd5,  8'h22, -1, 0, 2'b10, 32'h1234,     32'd1, 32'd2};
      vt[3] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd5,  8'h33, 15, 0, 2'b00, 32'h1234,     32'd2, 32'd2};
      vt[4] = '{1'b1, 4'd3,  32'h80,       1'b0, 4'd3,  8'h44,  0, 0, 2'b01, 32'h0,        32'd2, 32'd3};
      vt[5] = '{1'b1, 4'd15, 32'hFFFFFFFC, 1'b1, 4'd15, 8'hFF,  0, 5, 2'b00, 32'hFFFFFFFC, 32'd3, 32'd3};
      vt[6] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd3,  8'h55,  0, 5, 2'b01, 32'h0,        32'd3, 32'd4};

      rst = 1'b1; cfg_we_i = 1'b0; cfg_idx_i = '0; cfg_addr_i = '0; cfg_en_i = 1'b0;
      in_valid_i = 1'b0; in_action_i = '0; in_tag_i = '0; exec_done_i = 1'b0; out_ready_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_start", exec_start_o, 1'b0);
      chk("rst_addr", exec_start_addr_o, 32'h0);
      chk("rst_valid", out_valid_o, 1'b0);
      chk("rst_tag", out_tag_o, 8'h0);
      chk("rst_status", out_status_o, 2'b00);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_ok", cnt_ok_o, 32'h0);
      chk("rst_err", {16'h0, cnt_err_o}, 32'h0);
      chk("rst_ready", in_ready_o, 1'b1);
      rst = 1'b0;

      for (int v = 0; v < 7; v++) begin
         if (vt[v].wr) cfg_write(vt[v].widx, vt[v].waddr, vt[v].wen);
         run_pkt(vt[v].act, vt[v].tag, vt[v].dly, vt[v].hold, vt[v].st,
                 vt[v].eaddr, vt[v].ok, vt[v].err);
      end

      // Table write in the LOOKUP cycle: lookup must still see the old (invalid) entry.
      accept(4'd9, 8'h88);
      cfg_we_i = 1'b1; cfg_idx_i = 4'd9; cfg_addr_i = 32'h900; cfg_en_i = 1'b1;
      @(negedge clk);
      cfg_we_i = 1'b0;
      chk("sc_nostart", exec_start_o, 1'b0);
      chk("sc_valid", out_valid_o, 1'b1);
      chk("sc_status", out_status_o, 2'b01);
      out_ready_i = 1'b1;
      @(negedge clk);
      out_ready_i = 1'b0;
      chk("sc_err", {16'h0, cnt_err_o}, 32'd5);
      run_pkt(4'd9, 8'h99, 2, 0, 2'b00, 32'h900, 32'd4, 32'd5);

      // Executor keeps done high 3 cycles after start drops; queued packet must wait.
      accept(4'd15, 8'h66);
      @(negedge clk);
      chk("dh_start", exec_start_o, 1'b1);
      exec_done_i = 1'b1;
      @(negedge clk);
      chk("dh_drop", exec_start_o, 1'b0);
      chk("dh_valid", out_valid_o, 1'b1);
      out_ready_i = 1'b1;
      @(negedge clk);
      out_ready_i = 1'b0;
      chk("dh_ok", cnt_ok_o, 32'd5);
      chk("dh_idle", busy_o, 1'b0);
      chk("dh_block1", in_ready_o, 1'b0);
      in_valid_i = 1'b1; in_action_i = 4'd5; in_tag_i = 8'h77;
      @(negedge clk);
      chk("dh_block2", in_ready_o, 1'b0);
      chk("dh_notacc", busy_o, 1'b0);
      exec_done_i = 1'b0;
      #1;
      chk("dh_ready", in_ready_o, 1'b1);
      @(negedge clk);
      in_valid_i = 1'b0;
      chk("dh_acc", busy_o, 1'b1);
      @(negedge clk);
      chk("dh_start2", exec_start_o, 1'b1);
      chk("dh_addr2", exec_start_addr_o, 32'h1234);
      exec_done_i = 1'b1;
      @(negedge clk);
      chk("dh_valid2", out_valid_o, 1'b1);
      chk("dh_tag2", out_tag_o, 8'h77);
      exec_done_i = 1'b0;
      out_ready_i = 1'b1;
      @(negedge clk);
      out_ready_i = 1'b0;
      chk("dh_ok2", cnt_ok_o, 32'd6);

      // Reset during WAIT aborts and wipes the table.
      cfg_write(4'd3, 32'h40, 1'b1);
      accept(4'd3, 8'hA0);
      @(negedge clk);
      chk("rw_start", exec_start_o, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rw_start_lo", exec_start_o, 1'b0);
      chk("rw_valid_lo", out_valid_o, 1'b0);
      chk("rw_idle", busy_o, 1'b0);
      chk("rw_ok", cnt_ok_o, 32'd0);
      run_pkt(4'd3, 8'hA1, 0, 0, 2'b01, 32'h0, 32'd0, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
